// File: rtl/bist_controller_param_if.sv
// Test-interface bundle between the BIST controller and the top-level tester / datapath.
// The master drives launch, loop and signature; the slave (controller) drives phase and result flags.
interface bist_controller_param_if #(
    parameter int SIG_W = 16,
    parameter int PAT_W = 4,
    parameter int RND_W = 2
);
    logic             start;
    logic             loop;
    logic [SIG_W-1:0] misr_sig;
    logic             init;
    logic             running;
    logic             toggle;
    logic             finish;
    logic             bist_end;
    logic             pass;
    logic             result_valid;
    logic             busy;
    logic [PAT_W-1:0] pattern_idx;
    logic [RND_W-1:0] round_idx;

    modport master (
        output start, loop, misr_sig,
        input  init, running, toggle, finish, bist_end, pass, result_valid, busy,
               pattern_idx, round_idx
    );

    modport slave (
        input  start, loop, misr_sig,
        output init, running, toggle, finish, bist_end, pass, result_valid, busy,
               pattern_idx, round_idx
    );
endinterface

// File: rtl/bist_controller_param.sv
// Parametrised BIST sequencer: INIT -> RUN -> (TOGGLE -> RUN)* -> FINISH -> END, with golden
// signature compare and optional back-to-back looping.
module bist_controller_param #(
    parameter int               INIT_CYCLES = 2,
    parameter int               PATTERNS    = 16,
    parameter int               ROUNDS      = 2,
    parameter int               SIG_W       = 16,
    parameter logic [SIG_W-1:0] GOLDEN      = 16'hA5C3
) (
    input logic                    clk,
    input logic                    reset,
    bist_controller_param_if.slave bus
);

    localparam int PAT_W  = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;
    localparam int RND_W  = $clog2(ROUNDS) + 1;
    localparam int INIT_W = $clog2(INIT_CYCLES) + 1;

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(PATTERNS - 1);
    localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_TOGGLE,
        S_FINISH,
        S_END
    } state_t;

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [RND_W-1:0]    rnd_q, rnd_d;
    logic                pass_q, pass_d;
    logic                rv_q, rv_d;
    logic                start_prev_q;
    logic                launch;

    // start_prev resets high so a start held through reset release cannot launch
    assign launch = bus.start && !start_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            init_cnt_q   <= '0;
            pat_q        <= '0;
            rnd_q        <= '0;
            pass_q       <= 1'b0;
            rv_q         <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            pat_q        <= pat_d;
            rnd_q        <= rnd_d;
            pass_q       <= pass_d;
            rv_q         <= rv_d;
            start_prev_q <= bus.start;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pat_d      = pat_q;
        rnd_d      = rnd_q;
        pass_d     = pass_q;
        rv_d       = rv_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                    rnd_d      = '0;
                    pass_d     = 1'b0;
                    rv_d       = 1'b0;
                end
            end
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_RUN;
                    pat_d   = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (pat_q == PAT_LAST) begin
                    pat_d   = '0;
                    state_d = (rnd_q < RND_LAST) ? S_TOGGLE : S_FINISH;
                end else begin
                    pat_d = pat_q + 1'b1;
                end
            end
            S_TOGGLE: begin
                state_d = S_RUN;
                rnd_d   = rnd_q + 1'b1;
                pat_d   = '0;
            end
            S_FINISH: begin
                state_d = S_END;
                pass_d  = (bus.misr_sig == GOLDEN);
                rv_d    = 1'b1;
            end
            S_END: begin
                // Looping re-enters INIT directly, clearing the previous result like a fresh launch
                if (bus.loop) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                    rnd_d      = '0;
                    pass_d     = 1'b0;
                    rv_d       = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.init         = (state_q == S_INIT);
    assign bus.running      = (state_q == S_RUN);
    assign bus.toggle       = (state_q == S_TOGGLE);
    assign bus.finish       = (state_q == S_FINISH);
    assign bus.bist_end     = (state_q == S_END);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.pass         = pass_q;
    assign bus.result_valid = rv_q;
    assign bus.pattern_idx  = (state_q == S_RUN) ? pat_q : '0;
    assign bus.round_idx    = rnd_q;

endmodule

// File: tb/tb_bist_controller_param.sv
// Bench for bist_controller_param: per-cycle comparison against a timeline model derived
// from the phase lengths, with randomized signatures and idle gaps.
module tb_bist_controller_param;

    localparam int               IC   = 2;
    localparam int               P    = 16;
    localparam int               R    = 2;
    localparam int               SW   = 16;
    localparam logic [SW-1:0]    GOLD = 16'hA5C3;
    localparam int               PW   = 4;
    localparam int               RW   = 2;
    localparam int               VW   = 6 + PW + RW;
    localparam int               T    = IC + R*P + (R-1) + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   idle_rnd = 0;
    bit   idle_rv = 1'b0;
    bit   idle_pass = 1'b0;

    bist_controller_param_if #(.SIG_W(SW), .PAT_W(PW), .RND_W(RW)) bus ();

    bist_controller_param #(
        .INIT_CYCLES(IC), .PATTERNS(P), .ROUNDS(R), .SIG_W(SW), .GOLDEN(GOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected control outputs k cycles after the launch cycle (k=0 means idle)
    function automatic logic [VW-1:0] model_vec(input int k, input int idle_r);
        logic i, ru, tg, fi, be, bu;
        int   m, pi, ri;
        i = 0; ru = 0; tg = 0; fi = 0; be = 0; bu = 0; pi = 0; ri = idle_r;
        if (k >= 1) begin
            bu = 1; ri = 0;
            if (k <= IC) i = 1;
            else begin
                m = k - IC - 1;
                if (m < R*(P+1) - 1) begin
                    ri = m / (P+1);
                    if (m % (P+1) == P) tg = 1;
                    else begin ru = 1; pi = m % (P+1); end
                end else if (m == R*(P+1) - 1) begin
                    fi = 1; ri = R - 1;
                end else begin
                    be = 1; ri = R - 1;
                end
            end
        end
        return {i, ru, tg, fi, be, bu, PW'(pi), RW'(ri)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.init, bus.running, bus.toggle, bus.finish, bus.bist_end, bus.busy,
                bus.pattern_idx, bus.round_idx};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input int k, input bit rv, input bit ps);
        chk({tag, "_ctl"}, 32'(obs_vec()), 32'(model_vec(k, idle_rnd)));
        chk({tag, "_res"}, {30'd0, bus.result_valid, bus.pass}, {30'd0, rv, ps});
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_cycle("idle", 0, idle_rv, idle_pass);
        end
    endtask

    // One launch; misr_sig carries sig only during FINISH so a mistimed capture shows up
    task automatic run_once(input logic [SW-1:0] sig, input int restart_k, input int reset_k);
        bit ep;
        ep = (sig == GOLD);
        bus.misr_sig = ~sig;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= T; k++) begin
            chk_cycle("run", k, (k == T), (k == T) && ep);
            if (k == T - 1) bus.misr_sig = sig;
            else bus.misr_sig = ~sig;
            if (k == restart_k) bus.start = 1'b1;
            else if (k == restart_k + 1) bus.start = 1'b0;
            if (k == reset_k) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                idle_rnd = 0; idle_rv = 1'b0; idle_pass = 1'b0;
                chk_cycle("rst_mid", 0, 1'b0, 1'b0);
                return;
            end
            tick();
        end
        idle_rnd = R - 1; idle_rv = 1'b1; idle_pass = ep;
        chk_cycle("post", 0, idle_rv, idle_pass);
    endtask

    initial begin
        int ends, last_end, k, run_no;
        logic [SW-1:0] rs;

        bus.start = 1'b0; bus.loop = 1'b0; bus.misr_sig = '0; reset = 1'b1;
        repeat (3) tick();
        chk_cycle("reset", 0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_cycle("idle0", 0, 1'b0, 1'b0);

        // Golden signature, then a failing one, then a relaunch from IDLE
        run_once(GOLD, -5, -5);
        idle_gap($urandom_range(1, 5));
        run_once(16'h0000, -5, -5);
        idle_gap($urandom_range(1, 5));
        rs = 16'($urandom);
        run_once(rs, -5, -5);
        idle_gap(2);

        // Start re-issued mid-run is ignored
        run_once(GOLD, 30, -5);
        idle_gap(3);

        // Reset mid-RUN, then a clean run 15 cycles later
        run_once(16'($urandom), -5, 10);
        idle_gap(15);
        run_once(GOLD, -5, -5);

        // Start held high through reset release must not launch
        reset = 1'b1; bus.start = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        idle_rnd = 0; idle_rv = 1'b0; idle_pass = 1'b0;
        chk_cycle("rst_start", 0, 1'b0, 1'b0);
        idle_gap(3);
        bus.start = 1'b0;
        idle_gap(1);
        run_once(GOLD, -5, -5);
        idle_gap(2);

        // Loop mode: three back-to-back runs, loop dropped during the third
        bus.loop = 1'b1; bus.misr_sig = GOLD;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ends = 0; last_end = -1;
        for (int n = 0; n < 3*T; n++) begin
            k = n % T + 1;
            run_no = n / T;
            chk_cycle("loop", k, (k == T), (k == T));
            if (bus.bist_end === 1'b1) begin
                if (last_end >= 0) chk("loop_gap", n - last_end, T);
                last_end = n;
                ends++;
            end
            if (run_no == 2 && k == 5) bus.loop = 1'b0;
            tick();
        end
        chk("loop_ends", ends, 3);
        idle_rnd = R - 1; idle_rv = 1'b1; idle_pass = 1'b1;
        chk_cycle("loop_exit", 0, idle_rv, idle_pass);
        idle_gap(3);

        // Random signatures with random gaps
        for (int j = 0; j < 3; j++) begin
            rs = ($urandom_range(0, 1) == 1) ? GOLD : 16'($urandom);
            run_once(rs, -5, -5);
            idle_gap($urandom_range(1, 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
